branch_target_buffer: RTL and testbench

//  Parametrised branch predictor: direct-mapped BTB with per-entry 2-bit saturating counters.

---
 rtl/branch_target_buffer.sv | 141 ++++++++++++++
 tb/tb_branch_target_buffer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters, registered mispredict
// flush/redirect and a multi-cycle invalidation sweep. Define BTB_STATS_EN for statistics counters.
module branch_target_buffer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned TAG_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_is_cond,
    input  logic                  upd_taken,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_pred_taken,
    input  logic [ADDR_WIDTH-1:0] upd_pred_target,
    input  logic                  flush_all,
    output logic                  busy,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [31:0]           stat_lookups,
    output logic [31:0]           stat_mispred
);
    localparam int unsigned IDX = $clog2(ENTRIES);

    typedef enum logic [0:0] {ST_IDLE, ST_SWEEP} state_t;

    state_t                state_q, state_d;
    logic [IDX-1:0]        ptr_q;
    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];

    logic [IDX-1:0]        if_idx, upd_idx;
    logic [TAG_WIDTH-1:0]  if_tag, upd_tag;
    logic                  idle, if_hit, upd_hit, upd_en, mispredict;
    logic [1:0]            ctr_upd;
    logic                  unused_pc_bits;

    assign if_idx  = if_pc[IDX+1:2];
    assign if_tag  = if_pc[IDX+2 +: TAG_WIDTH];
    assign upd_idx = upd_pc[IDX+1:2];
    assign upd_tag = upd_pc[IDX+2 +: TAG_WIDTH];
    assign unused_pc_bits = ^{if_pc, upd_pc};

    assign idle = (state_q == ST_IDLE);
    assign busy = ~idle;

    // Lookup sees pre-edge table contents, so same-cycle updates are invisible here.
    assign if_hit      = if_valid & valid_q[if_idx] & (tag_q[if_idx] == if_tag) & idle;
    assign pred_taken  = if_hit & ctr_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : if_pc + ADDR_WIDTH'(4);

    assign upd_en  = upd_valid & idle;
    assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);

    assign mispredict = upd_valid & ((upd_taken != upd_pred_taken)
                                     | (upd_taken & (upd_target != upd_pred_target)));

    always_comb begin
        ctr_upd = ctr_q[upd_idx];
        if (!upd_is_cond) begin
            ctr_upd = 2'b11;
        end else if (upd_taken) begin
            ctr_upd = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
        end else begin
            ctr_upd = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (flush_all) state_d = ST_SWEEP;
            ST_SWEEP: if (ptr_q == IDX'(ENTRIES - 1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            valid_q     <= '0;
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            state_q <= state_d;
            flush   <= mispredict;
            if (mispredict) begin
                redirect_pc <= upd_taken ? upd_target : upd_pc + ADDR_WIDTH'(8);
            end
            if (!idle) begin
                valid_q[ptr_q] <= 1'b0;
                ptr_q          <= ptr_q + IDX'(1);
            end else if (upd_en & ~upd_hit & upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
            end
        end
    end

    // Payload fields need no reset: they are only observed behind valid.
    always_ff @(posedge clk) begin
        if (upd_en) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= ctr_upd;
                if (upd_taken) target_q[upd_idx] <= upd_target;
            end else if (upd_taken) begin
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= upd_is_cond ? 2'b10 : 2'b11;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] lookups_q, mispred_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookups_q <= '0;
            mispred_q <= '0;
        end else begin
            if (if_valid & idle) lookups_q <= lookups_q + 32'd1;
            if (mispredict)      mispred_q <= mispred_q + 32'd1;
        end
    end

    assign stat_lookups = lookups_q;
    assign stat_mispred = mispred_q;
`else
    assign stat_lookups = '0;
    assign stat_mispred = '0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: stimulus queues expected lookups/flushes,
// a negedge monitor pops and compares them as the DUT presents results.
module tb_branch_target_buffer;
    localparam int unsigned AW = 32;
    localparam int unsigned N  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_valid;
    logic [AW-1:0] if_pc;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic          upd_valid;
    logic [AW-1:0] upd_pc;
    logic          upd_is_cond;
    logic          upd_taken;
    logic [AW-1:0] upd_target;
    logic          upd_pred_taken;
    logic [AW-1:0] upd_pred_target;
    logic          flush_all;
    logic          busy;
    logic          flush;
    logic [AW-1:0] redirect_pc;
    logic [31:0]   stat_lookups;
    logic [31:0]   stat_mispred;

    always #5 clk = ~clk;

    branch_target_buffer #(.ADDR_WIDTH(AW), .ENTRIES(N), .TAG_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .flush_all(flush_all), .busy(busy),
        .flush(flush), .redirect_pc(redirect_pc),
        .stat_lookups(stat_lookups), .stat_mispred(stat_mispred)
    );

    typedef struct { logic taken; logic [AW-1:0] target; } look_t;
    typedef struct { int cyc; logic [AW-1:0] pc; } flush_t;

    look_t  look_q[$];
    flush_t flush_q[$];
    int     tests = 0;
    int     fails = 0;
    int     cyc   = 0;
    int     busy_cycles;
    int     n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: flush is due exactly on its queued cycle; any other flush is spurious.
    always @(negedge clk) begin
        if (!rst) begin
            if (flush_q.size() > 0 && flush_q[0].cyc == cyc) begin
                flush_t e;
                e = flush_q.pop_front();
                check("flush", 32'(flush), 32'd1);
                if (flush) check("redirect_pc", redirect_pc, e.pc);
            end else if (flush) begin
                check("spurious_flush", 32'(flush), 32'd0);
            end
            if (if_valid && look_q.size() > 0) begin
                look_t l;
                l = look_q.pop_front();
                check("pred_taken", 32'(pred_taken), 32'(l.taken));
                check("pred_target", pred_target, l.target);
            end
        end
    end

    task automatic clear_inputs();
        if_valid = 1'b0; if_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_is_cond = 1'b0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        flush_all = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic lookup(input logic [AW-1:0] pc, input logic t, input logic [AW-1:0] tgt);
        look_t l;
        if_valid = 1'b1;
        if_pc    = pc;
        l.taken  = t;
        l.target = tgt;
        look_q.push_back(l);
    endtask

    task automatic update(input logic [AW-1:0] pc, input logic cond, input logic taken,
                          input logic [AW-1:0] tgt, input logic pt, input logic [AW-1:0] ptgt,
                          input logic exp_fl, input logic [AW-1:0] exp_redir);
        flush_t f;
        upd_valid = 1'b1; upd_pc = pc; upd_is_cond = cond; upd_taken = taken;
        upd_target = tgt; upd_pred_taken = pt; upd_pred_target = ptgt;
        if (exp_fl) begin
            f.cyc = cyc + 1;
            f.pc  = exp_redir;
            flush_q.push_back(f);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // T1: reset state and an empty-table lookup
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_flush", 32'(flush), 32'd0);
        check("reset_redirect", redirect_pc, 32'd0);
        check("reset_stat_lookups", stat_lookups, 32'd0);
        check("reset_stat_mispred", stat_mispred, 32'd0);
        lookup(32'h400, 1'b0, 32'h404); tick();

        // T2: conditional taken allocates with ctr=2
        update(32'h400, 1, 1, 32'h500, 0, 32'h0, 1, 32'h500); tick();
        lookup(32'h400, 1'b1, 32'h500); tick();

        // T3: two not-taken updates 2->1->0, then saturation at 0
        update(32'h400, 1, 0, 32'h0, 1, 32'h500, 1, 32'h408); tick();
        update(32'h400, 1, 0, 32'h0, 1, 32'h500, 1, 32'h408); tick();
        lookup(32'h400, 1'b0, 32'h404); tick();
        update(32'h400, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0); tick();
        update(32'h400, 1, 1, 32'h540, 0, 32'h0, 1, 32'h540); tick();
        lookup(32'h400, 1'b0, 32'h404); tick();
        update(32'h400, 1, 1, 32'h540, 0, 32'h0, 1, 32'h540); tick();
        lookup(32'h400, 1'b1, 32'h540); tick();

        // T4: JR at 0x600 replaces idx 0 with ctr=3, then a correct prediction
        update(32'h600, 0, 1, 32'h700, 0, 32'h0, 1, 32'h700); tick();
        lookup(32'h400, 1'b0, 32'h404); tick();
        lookup(32'h600, 1'b1, 32'h700); tick();
        update(32'h600, 0, 1, 32'h700, 1, 32'h700, 0, 32'h0);
        lookup(32'h600, 1'b1, 32'h700); tick();
        update(32'h600, 1, 0, 32'h0, 1, 32'h700, 1, 32'h608); tick();
        lookup(32'h600, 1'b1, 32'h700); tick();

        // T5: fill entries 1..3, sweep with injected lookup/update/flush_all
        update(32'h104, 1, 1, 32'h900, 0, 32'h0, 1, 32'h900); tick();
        update(32'h108, 1, 1, 32'h904, 0, 32'h0, 1, 32'h904); tick();
        update(32'h10C, 1, 1, 32'h908, 0, 32'h0, 1, 32'h908); tick();
        lookup(32'h104, 1'b1, 32'h900); tick();
        lookup(32'h108, 1'b1, 32'h904); tick();
        lookup(32'h10C, 1'b1, 32'h908); tick();
        lookup(32'h600, 1'b1, 32'h700); tick();
        flush_all = 1'b1; tick();
        busy_cycles = 0;
        for (int c = 0; c < int'(N) + 4; c++) begin
            if (c == 2) lookup(32'h10C, 1'b0, 32'h110);
            if (c == 3) update(32'h200, 1, 1, 32'hA00, 0, 32'h0, 1, 32'hA00);
            if (c == 4) flush_all = 1'b1;
            @(negedge clk);
            if (busy) busy_cycles++;
            tick();
        end
        check("sweep_busy_cycles", busy_cycles, N);
        lookup(32'h600, 1'b0, 32'h604); tick();
        lookup(32'h104, 1'b0, 32'h108); tick();
        lookup(32'h108, 1'b0, 32'h10C); tick();
        lookup(32'h10C, 1'b0, 32'h110); tick();
        lookup(32'h200, 1'b0, 32'h204); tick();

        // T5b: asynchronous reset in the middle of a sweep
        update(32'h104, 1, 1, 32'h900, 0, 32'h0, 1, 32'h900); tick();
        tick();
        flush_all = 1'b1; tick();
        tick(); tick();
        check("busy_mid_sweep", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1 check("busy_async_rst", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        lookup(32'h104, 1'b0, 32'h108); tick();
        flush_all = 1'b1; tick();
        busy_cycles = 0;
        for (int c = 0; c < int'(N) + 2; c++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            tick();
        end
        check("sweep_after_rst_cycles", busy_cycles, N);

        // T6: statistics, 8 idle lookups + 2 during sweep + 3 mispredicts
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            lookup(32'h1000 + 32'(i) * 32'd4, 1'b0, 32'h1004 + 32'(i) * 32'd4);
            tick();
        end
        flush_all = 1'b1; tick();
        lookup(32'h1000, 1'b0, 32'h1004); tick();
        lookup(32'h1004, 1'b0, 32'h1008); tick();
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("sweep_done", 32'(busy), 32'd0);
        update(32'h300, 1, 1, 32'h380, 0, 32'h0, 1, 32'h380); tick();
        update(32'h340, 1, 1, 32'h3C0, 1, 32'h3A0, 1, 32'h3C0); tick();
        update(32'h384, 1, 0, 32'h0, 1, 32'h390, 1, 32'h38C); tick();
        tick(); tick();
`ifdef BTB_STATS_EN
        check("stat_lookups", stat_lookups, 32'd8);
        check("stat_mispred", stat_mispred, 32'd3);
`else
        check("stat_lookups", stat_lookups, 32'd0);
        check("stat_mispred", stat_mispred, 32'd0);
`endif
        tick();
        check("lookup_queue_drained", 32'(look_q.size()), 32'd0);
        check("flush_queue_drained", 32'(flush_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
